inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Byte-serial instruction fetch: reads four bytes from a byte-wide memory, assembles a
// big-endian word and hands it to decode with a valid/ready handshake; supports redirects.
//
// state | meaning
// START | one idle cycle after reset, no reads
// FETCH | issuing byte reads 0..3 at pc+byte_cnt
// DRAIN | last byte returning; word and pc loaded to outputs
// VALID | word presented, waiting for instReady
// ERROR | illegal redirect seen; waits for a legal one
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [$clog2(MEM_DEPTH)-1:0] memAddr,
    output logic                         memRdEn,
    input  logic [7:0]                   memData,
    input  logic                         branchValid,
    input  logic [31:0]                  branchTarget,
    output logic                         instValid,
    input  logic                         instReady,
    output logic [31:0]                  Instruction,
    output logic [31:0]                  instPC,
    output logic                         fetchErr
);

    localparam int          AW         = $clog2(MEM_DEPTH);
    localparam logic [31:0] PC_MASK    = 32'(MEM_DEPTH - 1);
    localparam logic [31:0] MAX_TARGET = 32'(MEM_DEPTH - 4);

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DRAIN,
        ST_VALID,
        ST_ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [1:0]  cnt_d;
    logic        rd_d;
    logic [23:0] word_buf;
    logic [31:0] pc;
    logic        take_branch;
    logic        branch_legal;
    logic        handshake;

    assign branch_legal = (branchTarget[1:0] == 2'b00) && (branchTarget <= MAX_TARGET);
    assign take_branch  = branchValid && (state != ST_START);
    assign handshake    = instValid && instReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (take_branch) begin
            state_nxt = branch_legal ? ST_FETCH : ST_ERROR;
        end else begin
            case (state)
                ST_START: state_nxt = ST_FETCH;
                ST_FETCH: if (byte_cnt == 2'd3) state_nxt = ST_DRAIN;
                ST_DRAIN: state_nxt = ST_VALID;
                ST_VALID: if (instReady) state_nxt = ST_FETCH;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        memRdEn   = 1'b0;
        memAddr   = '0;
        instValid = 1'b0;
        case (state)
            ST_FETCH: begin
                memRdEn = 1'b1;
                memAddr = pc[AW-1:0] + AW'(byte_cnt);
            end
            ST_VALID: instValid = 1'b1;
            default: ;
        endcase
    end

    // A redirect kills the delayed read strobe so the byte returning next cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= 2'd0;
            cnt_d       <= 2'd0;
            rd_d        <= 1'b0;
            word_buf    <= '0;
            Instruction <= '0;
            instPC      <= '0;
            pc          <= RESET_PC;
            fetchErr    <= 1'b0;
        end else begin
            rd_d     <= memRdEn && !take_branch;
            cnt_d    <= byte_cnt;
            byte_cnt <= (state == ST_FETCH && !take_branch) ? byte_cnt + 2'd1 : 2'd0;

            if (rd_d && !take_branch) begin
                case (cnt_d)
                    2'd0:    word_buf[23:16] <= memData;
                    2'd1:    word_buf[15:8]  <= memData;
                    2'd2:    word_buf[7:0]   <= memData;
                    default: ;
                endcase
            end

            if (state == ST_DRAIN && rd_d && !take_branch) begin
                Instruction <= {word_buf, memData};
                instPC      <= pc;
            end

            if (take_branch) begin
                fetchErr <= !branch_legal;
                if (branch_legal) pc <= branchTarget;
            end else if (handshake) begin
                pc <= (pc + 32'd4) & PC_MASK;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus randomized ready/redirect traffic,
// checked by a negedge monitor against a queue of expected word addresses.
module tb_inst_fetch_ctrl;

    localparam int          D   = 256;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  memAddr;
    logic        memRdEn;
    logic [7:0]  memData;
    logic        branchValid;
    logic [31:0] branchTarget;
    logic        instValid;
    logic        instReady;
    logic [31:0] Instruction;
    logic [31:0] instPC;
    logic        fetchErr;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.RESET_PC(RPC), .MEM_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memAddr      (memAddr),
        .memRdEn      (memRdEn),
        .memData      (memData),
        .branchValid  (branchValid),
        .branchTarget (branchTarget),
        .instValid    (instValid),
        .instReady    (instReady),
        .Instruction  (Instruction),
        .instPC       (instPC),
        .fetchErr     (fetchErr)
    );

    // Memory returns the byte one cycle after a read; junk otherwise to expose stale captures.
    logic [7:0] mem [D];
    always @(posedge clk) memData <= memRdEn ? mem[memAddr] : 8'($urandom);

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
    endfunction

    function automatic bit legal(input logic [31:0] t);
        return (t[1:0] == 2'b00) && (t <= 32'(D - 4));
    endfunction

    // Reference model: the queue holds the address of the next word decode should receive.
    logic [31:0] exp_q[$];
    bit          err_exp;
    bit          low_next;
    bit          hold_prev;
    bit          prev_v;
    int          k = -1;
    int          burst_start = 0;
    logic [31:0] base;
    logic [31:0] prev_instr;
    logic [31:0] prev_pcv;
    logic [31:0] mon_p;
    bit          mon_hs;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(RPC);
            err_exp   = 1'b0;
            low_next  = 1'b0;
            hold_prev = 1'b0;
            prev_v    = 1'b0;
            k         = -1;
        end else begin
            chk("fetch_err", 32'(fetchErr), 32'(err_exp));
            if (low_next) chk("valid_after_event", 32'(instValid), 32'd0);
            if (instValid) chk("rd_during_valid", 32'(memRdEn), 32'd0);
            if (instValid && hold_prev) begin
                chk("hold_instr", Instruction, prev_instr);
                chk("hold_pc", instPC, prev_pcv);
            end
            if (instValid && !prev_v) chk("latency", 32'(cyc - burst_start), 32'd5);
            if (memRdEn) begin
                if (k < 0) begin
                    k = 0;
                    burst_start = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got read at %h, required no read", memAddr);
                        base = 32'(memAddr);
                    end else begin
                        base = exp_q[0];
                    end
                end
                chk("rd_addr", 32'(memAddr), (base + 32'(k)) & 32'(D - 1));
                chk("burst_len", 32'(k), (k < 4) ? 32'(k) : 32'd3);
                k++;
            end else begin
                k = -1;
            end

            mon_hs = instValid && instReady;
            mon_p  = 32'hFFFF_FFFF;
            if (mon_hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got pc %h, required no word", instPC);
                end else begin
                    mon_p = exp_q.pop_front();
                    chk("inst_pc", instPC, mon_p);
                    chk("instruction", Instruction, word_at(mon_p));
                end
            end

            low_next = 1'b0;
            if (branchValid) begin
                exp_q.delete();
                k        = -1;
                low_next = 1'b1;
                if (legal(branchTarget)) begin
                    exp_q.push_back(branchTarget);
                    err_exp = 1'b0;
                end else begin
                    err_exp = 1'b1;
                end
            end else if (mon_hs) begin
                low_next = 1'b1;
                if (mon_p != 32'hFFFF_FFFF) exp_q.push_back((mon_p + 32'd4) & 32'(D - 1));
            end
            hold_prev  = instValid && !mon_hs && !branchValid;
            prev_instr = Instruction;
            prev_pcv   = instPC;
            prev_v     = instValid;
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (instValid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: instValid 0 for %0d cycles, required 1", budget);
        end
    endtask

    task automatic wait_rd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (memRdEn) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_rd: memRdEn 0 for %0d cycles, required 1", budget);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic branch_to(input logic [31:0] t);
        step();
        branchValid  = 1'b1;
        branchTarget = t;
        step();
        branchValid  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},    32'(memRdEn),   32'd0);
        chk({tag, "_addr"},  32'(memAddr),   32'd0);
        chk({tag, "_valid"}, 32'(instValid), 32'd0);
        chk({tag, "_instr"}, Instruction,    32'd0);
        chk({tag, "_pc"},    instPC,         32'd0);
        chk({tag, "_err"},   32'(fetchErr),  32'd0);
    endtask

    initial begin
        bit ok;
        rst_n        = 1'b0;
        branchValid  = 1'b0;
        branchTarget = '0;
        instReady    = 1'b1;
        for (int i = 0; i < D; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h01;
        mem[1] = 8'h23;
        mem[2] = 8'h45;
        mem[3] = 8'h67;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_no_read", 32'(memRdEn), 32'd0);
        @(negedge clk);
        chk("first_read", 32'(memRdEn), 32'd1);
        chk("first_addr", 32'(memAddr), RPC);

        // first word, consumed immediately
        wait_valid(20, ok);
        if (ok) begin
            chk("word0_instr", Instruction, 32'h0123_4567);
            chk("word0_pc", instPC, 32'd0);
        end

        // decode stalls for ten cycles
        step();
        instReady = 1'b0;
        wait_valid(20, ok);
        if (ok) chk("stall_pc", instPC, 32'd4);
        repeat (10) @(negedge clk);
        chk("stall_rd", 32'(memRdEn), 32'd0);
        chk("stall_valid", 32'(instValid), 32'd1);
        step();
        instReady = 1'b1;

        // redirect while byte 2 is being read
        wait_rd(20, ok);
        step();
        step();
        branchValid  = 1'b1;
        branchTarget = 32'h10;
        step();
        branchValid  = 1'b0;
        wait_valid(20, ok);
        if (ok) chk("redirect_pc", instPC, 32'h10);

        // illegal redirects, then recovery
        branch_to(32'h06);
        @(negedge clk);
        chk("misaligned_err", 32'(fetchErr), 32'd1);
        chk("misaligned_valid", 32'(instValid), 32'd0);
        branch_to(32'h104);
        @(negedge clk);
        chk("range_err", 32'(fetchErr), 32'd1);
        repeat (3) @(negedge clk);
        branch_to(32'h20);
        @(negedge clk);
        chk("recover_err", 32'(fetchErr), 32'd0);
        wait_valid(20, ok);
        if (ok) chk("recover_pc", instPC, 32'h20);

        // wrap from the last word of memory
        branch_to(32'hFC);
        wait_valid(20, ok);
        if (ok) chk("last_word_pc", instPC, 32'hFC);
        step();
        wait_valid(20, ok);
        if (ok) begin
            chk("wrap_pc", instPC, 32'd0);
            chk("wrap_err", 32'(fetchErr), 32'd0);
        end

        for (int n = 0; n < 600; n++) begin
            step();
            instReady = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 6) begin
                branchValid = 1'b1;
                if ($urandom_range(0, 3) != 0) branchTarget = 32'($urandom_range(0, 63)) * 32'd4;
                else                           branchTarget = 32'($urandom_range(0, 300));
            end else begin
                branchValid = 1'b0;
            end
        end
        step();
        instReady    = 1'b1;
        branchValid  = 1'b1;
        branchTarget = 32'h40;
        step();
        branchValid  = 1'b0;

        // reset pulse during DRAIN
        wait_rd(20, ok);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_no_read", 32'(memRdEn), 32'd0);
        @(negedge clk);
        chk("restart_read", 32'(memRdEn), 32'd1);
        chk("restart_addr", 32'(memAddr), RPC);
        wait_valid(20, ok);
        if (ok) begin
            chk("restart_pc", instPC, RPC);
            chk("restart_instr", Instruction, 32'h0123_4567);
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1);
    end

endmodule
